// File: rtl/mlp_frame_sequencer.sv
// Purpose : frames a feature stream into the packed input of a slow combinational
//           classifier, waits a settle window, then returns the class index.
// Latency : class valid SETTLE_CYC edges after the last feature beat transfers.
// Backpr. : s_feat_ready low while settling or while a result waits for m_cls_ready.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   s_feat_*          feature beat stream in (valid/ready, data, last)
//   mlp_inp           registered packed classifier input, feature 0 in the low slot
//   mlp_out           classifier argmax output, sampled at the end of the settle window
//   m_cls_*           class result stream out (valid/ready, data)
//   err_frame         one-cycle pulse per malformed frame (early or missing last)
//   busy              high unless idle in LOAD with no partial frame collected
module mlp_frame_sequencer #(
    parameter int NUM_FEAT   = 8,
    parameter int FEAT_W     = 4,
    parameter int CLS_W      = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_feat_valid,
    output logic                       s_feat_ready,
    input  logic [FEAT_W-1:0]          s_feat_data,
    input  logic                       s_feat_last,
    output logic [NUM_FEAT*FEAT_W-1:0] mlp_inp,
    input  logic [CLS_W-1:0]           mlp_out,
    output logic                       m_cls_valid,
    input  logic                       m_cls_ready,
    output logic [CLS_W-1:0]           m_cls_data,
    output logic                       err_frame,
    output logic                       busy
);

    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_DROP   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_FEAT - 1);
    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYC - 1);

    logic [1:0]                 r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [NUM_FEAT*FEAT_W-1:0] r_inp;
    logic [7:0]                 r_cnt;
    logic                       r_cls_vld;
    logic [CLS_W-1:0]           r_cls_dat;
    logic                       r_err;
    // Keeps ready low until the first edge after reset release.
    logic                       r_started;

    logic w_accepting;
    logic w_xfer;
    logic w_at_last;

    assign w_accepting = r_started && ((r_state == ST_LOAD) || (r_state == ST_DROP));
    assign w_xfer      = s_feat_valid && w_accepting;
    assign w_at_last   = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_LOAD;
            r_idx     <= '0;
            r_inp     <= '0;
            r_cnt     <= '0;
            r_cls_vld <= 1'b0;
            r_cls_dat <= '0;
            r_err     <= 1'b0;
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
            r_err     <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_xfer) begin
                        // Only the addressed slot is written; others keep old values.
                        for (int i = 0; i < NUM_FEAT; i++) begin
                            if (r_idx == IDX_W'(i)) begin
                                r_inp[i*FEAT_W +: FEAT_W] <= s_feat_data;
                            end
                        end
                        if (w_at_last && s_feat_last) begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= SETTLE_INIT;
                            r_idx   <= '0;
                        end else if (s_feat_last) begin
                            // Short frame: discard, restart collection in place.
                            r_err <= 1'b1;
                            r_idx <= '0;
                        end else if (w_at_last) begin
                            // Frame overran without last: swallow beats up to its last.
                            r_err   <= 1'b1;
                            r_idx   <= '0;
                            r_state <= ST_DROP;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_xfer && s_feat_last) begin
                        r_state <= ST_LOAD;
                        r_idx   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 8'd0) begin
                        r_cls_dat <= mlp_out;
                        r_cls_vld <= 1'b1;
                        r_state   <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_HOLD: begin
                    // No bypass to the feature side: ready returns the cycle after.
                    if (m_cls_ready) begin
                        r_cls_vld <= 1'b0;
                        r_state   <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign s_feat_ready = w_accepting;
    assign mlp_inp      = r_inp;
    assign m_cls_valid  = r_cls_vld;
    assign m_cls_data   = r_cls_dat;
    assign err_frame    = r_err;
    assign busy         = (r_state != ST_LOAD) || (r_idx != '0);

endmodule

// File: tb/tb_mlp_frame_sequencer.sv
// Bench for mlp_frame_sequencer: two instances (settle 4 and settle 1) driven from
// directed and randomized stimulus, checked every cycle against a frame-level model.
module tb_mlp_frame_sequencer;

    localparam int SET0 = 4;
    localparam int SET1 = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]       sv, sr, sl, mv, mr, ef, bz;
    logic [1:0][3:0]  sd;
    logic [1:0][31:0] inp;
    logic [1:0][1:0]  md;
    logic [1:0]       cls0;
    logic [1:0]       mo0, mo1;

    int n_chk  = 0;
    int n_fail = 0;
    int edge_n = 0;

    // Reference classifier for the randomized instance.
    function automatic logic [1:0] cls_fn(logic [31:0] w);
        return w[1:0] ^ w[17:16] ^ w[31:30];
    endfunction

    assign mo0 = cls0;
    assign mo1 = cls_fn(inp[1]);

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    mlp_frame_sequencer #(.SETTLE_CYC(SET0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_feat_valid(sv[0]), .s_feat_ready(sr[0]), .s_feat_data(sd[0]), .s_feat_last(sl[0]),
        .mlp_inp(inp[0]), .mlp_out(mo0),
        .m_cls_valid(mv[0]), .m_cls_ready(mr[0]), .m_cls_data(md[0]),
        .err_frame(ef[0]), .busy(bz[0])
    );

    mlp_frame_sequencer #(.SETTLE_CYC(SET1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_feat_valid(sv[1]), .s_feat_ready(sr[1]), .s_feat_data(sd[1]), .s_feat_last(sl[1]),
        .mlp_inp(inp[1]), .mlp_out(mo1),
        .m_cls_valid(mv[1]), .m_cls_ready(mr[1]), .m_cls_data(md[1]),
        .err_frame(ef[1]), .busy(bz[1])
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // pend  : a complete frame was accepted and its result has not been handed off
    // t_last: edge number on which the last beat of that frame transferred
    int          m_nb   [2];
    bit          m_drp  [2];
    bit          m_pend [2];
    bit          m_errq [2];
    bit          m_live [2];
    logic [31:0] m_img  [2];
    int          m_tlast[2];
    logic [1:0]  m_cls  [2];
    int          m_nres [2];
    int          m_nerr [2];
    int          m_set  [2];

    initial begin
        m_set[0] = SET0;
        m_set[1] = SET1;
        for (int u = 0; u < 2; u++) begin
            m_nres[u] = 0;
            m_nerr[u] = 0;
        end
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                bit e_rdy, e_vld, e_next;
                if (!rst_n) begin
                    m_nb[u] = 0; m_drp[u] = 0; m_pend[u] = 0; m_errq[u] = 0;
                    m_live[u] = 0; m_img[u] = '0;
                end
                e_rdy = rst_n && m_live[u] && !m_pend[u];
                e_vld = m_pend[u] && (edge_n >= m_tlast[u] + m_set[u]);
                chk($sformatf("inp%0d", u), inp[u], m_img[u]);
                chk($sformatf("rdy%0d", u), sr[u], e_rdy);
                chk($sformatf("vld%0d", u), mv[u], e_vld);
                chk($sformatf("err%0d", u), ef[u], m_errq[u]);
                chk($sformatf("busy%0d", u), bz[u], m_pend[u] || m_drp[u] || (m_nb[u] != 0));
                if (e_vld) chk($sformatf("cls%0d", u), md[u], m_cls[u]);
                if (rst_n) begin
                    e_next = 1'b0;
                    if (m_errq[u]) m_nerr[u]++;
                    if (m_pend[u] && edge_n == m_tlast[u] + m_set[u] - 1)
                        m_cls[u] = (u == 0) ? mo0 : cls_fn(m_img[u]);
                    if (e_vld && mr[u]) begin
                        m_pend[u] = 1'b0;
                        m_nres[u]++;
                    end
                    if (sv[u] && e_rdy) begin
                        if (m_drp[u]) begin
                            if (sl[u]) m_drp[u] = 1'b0;
                        end else begin
                            m_img[u][m_nb[u]*4 +: 4] = sd[u];
                            if (m_nb[u] == 7) begin
                                m_nb[u] = 0;
                                if (sl[u]) begin
                                    m_pend[u]  = 1'b1;
                                    m_tlast[u] = edge_n + 1;
                                end else begin
                                    e_next   = 1'b1;
                                    m_drp[u] = 1'b1;
                                end
                            end else if (sl[u]) begin
                                e_next  = 1'b1;
                                m_nb[u] = 0;
                            end else begin
                                m_nb[u]++;
                            end
                        end
                    end
                    m_errq[u] = e_next;
                    m_live[u] = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send_beat(int u, logic [3:0] d, bit l, bit gaps);
        int k = 0;
        if (gaps) while (k < 20 && $urandom_range(1, 0) == 1) begin cyc(); k++; end
        sv[u] = 1'b1; sd[u] = d; sl[u] = l;
        k = 0;
        while (!sr[u] && k < 200) begin cyc(); k++; end
        chk("beat_wait", k < 200, 1'b1);
        cyc();
        sv[u] = 1'b0; sl[u] = 1'b0;
    endtask

    task automatic send_frame(int u, logic [31:0] w, int n, bit last, bit gaps);
        for (int i = 0; i < n; i++) send_beat(u, w[i*4 +: 4], last && (i == n - 1), gaps);
    endtask

    task automatic wait_vld(int u, output int k);
        k = 0;
        while (!mv[u] && k < 50) begin cyc(); k++; end
    endtask

    task automatic wait_rdy(int u);
        int k = 0;
        while (!sr[u] && k < 50) begin cyc(); k++; end
        chk("rdy_wait", k < 50, 1'b1);
    endtask

    // ---------------- directed + random tests ----------------
    initial begin
        int k, e0, r0;
        logic [31:0] w;
        sv = '0; sl = '0; sd = '0; mr = 2'b11; cls0 = 2'b10;
        repeat (3) cyc();
        chk("rst_rdy", sr[0], 1'b0);
        chk("rst_inp", inp[0], 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("rdy_after_rel", sr[0], 1'b1);

        // Basic frame and latency.
        send_frame(0, 32'h87654321, 8, 1'b1, 1'b0);
        chk("t1_inp", inp[0], 32'h87654321);
        wait_vld(0, k);
        chk("t1_lat", k, SET0);
        chk("t1_cls", md[0], 2'd2);
        chk("t1_rdy_in_hold", sr[0], 1'b0);
        cyc();
        chk("t1_vld_drop", mv[0], 1'b0);
        chk("t1_rdy_back", sr[0], 1'b1);

        // Backpressure in HOLD.
        mr[0] = 1'b0;
        send_frame(0, 32'h13572468, 8, 1'b1, 1'b0);
        wait_vld(0, k);
        chk("t2_lat", k, SET0);
        cls0 = 2'b01;
        sv[0] = 1'b1; sd[0] = 4'h5; sl[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t2_hold_cls", md[0], 2'd2);
            chk("t2_hold_rdy", sr[0], 1'b0);
        end
        sv[0] = 1'b0;
        mr[0] = 1'b1;
        cyc();
        chk("t2_vld_drop", mv[0], 1'b0);
        chk("t2_inp_kept", inp[0], 32'h13572468);

        // Early last, then a good frame.
        e0 = m_nerr[0]; r0 = m_nres[0];
        send_frame(0, 32'h00000ABC, 3, 1'b1, 1'b0);
        send_frame(0, 32'hFFFFFFFF, 8, 1'b1, 1'b0);
        chk("t3_inp", inp[0], 32'hFFFFFFFF);
        wait_vld(0, k);
        cyc();
        wait_rdy(0);
        chk("t3_err_cnt", m_nerr[0] - e0, 1);
        chk("t3_res_cnt", m_nres[0] - r0, 1);

        // Missing last, junk beats dropped, then a good frame.
        e0 = m_nerr[0]; r0 = m_nres[0];
        send_frame(0, 32'hA5A5C3C3, 8, 1'b0, 1'b0);
        send_frame(0, 32'h00000999, 3, 1'b1, 1'b0);
        chk("t4_junk_kept", inp[0], 32'hA5A5C3C3);
        send_frame(0, 32'h76543210, 8, 1'b1, 1'b0);
        chk("t4_inp", inp[0], 32'h76543210);
        wait_vld(0, k);
        cyc();
        wait_rdy(0);
        chk("t4_err_cnt", m_nerr[0] - e0, 1);
        chk("t4_res_cnt", m_nres[0] - r0, 1);

        // Random frames with gaps on the settle-1 instance.
        r0 = m_nres[1];
        for (int f = 0; f < 24; f++) begin
            w = $urandom;
            send_frame(1, w, 8, 1'b1, 1'b1);
            chk("t5_inp", inp[1], w);
            wait_vld(1, k);
            chk("t5_lat", k, SET1);
            chk("t5_cls", md[1], cls_fn(w));
        end
        cyc();
        chk("t5_res_cnt", m_nres[1] - r0, 24);

        // Asynchronous reset mid-SETTLE.
        r0 = m_nres[0];
        send_frame(0, 32'h2468ACE1, 8, 1'b1, 1'b0);
        cyc();
        #1 rst_n = 1'b0;
        #1;
        chk("t6_inp", inp[0], 32'h0);
        chk("t6_vld", mv[0], 1'b0);
        chk("t6_busy", bz[0], 1'b0);
        cyc(); cyc();
        rst_n = 1'b1;
        repeat (12) cyc();
        chk("t6_no_res", m_nres[0] - r0, 0);

        // Asynchronous reset mid-HOLD.
        mr[0] = 1'b0;
        send_frame(0, 32'h0F1E2D3C, 8, 1'b1, 1'b0);
        wait_vld(0, k);
        chk("t7_lat", k, SET0);
        cyc();
        #1 rst_n = 1'b0;
        #1;
        chk("t7_inp", inp[0], 32'h0);
        chk("t7_vld", mv[0], 1'b0);
        chk("t7_cls", md[0], 2'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        mr[0] = 1'b1;
        r0 = m_nres[0];
        repeat (10) cyc();
        chk("t7_no_res", m_nres[0] - r0, 0);
        chk("t7_rdy", sr[0], 1'b1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mlp_frame_sequencer.md
Name: mlp_frame_sequencer

Overview:
- Drives the combinational classifier, with its 32-bit packed feature input (8 features × 4 bits, feature 0 in bits [3:0]) and its 2-bit class output.
- Accepts features one at a time over a valid/ready stream and assembles them into the classifier input register.
- Holds that input stable for a programmable settle window, since the printed-technology combinational path is slow.
- Captures the class index and returns it over a valid/ready result stream.

Parameters:
- NUM_FEAT, 8, features per frame.
- FEAT_W, 4, bits per feature.
- CLS_W, 2, class index width.
- SETTLE_CYC, 4, cycles mlp_inp is held before class capture (legal range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_feat_valid  in  1  feature beat valid.
- s_feat_ready  out  1  sequencer can accept a beat.
- s_feat_data  in  FEAT_W  unsigned feature value.
- s_feat_last  in  1  marks the final beat of a frame.
- mlp_inp  out  NUM_FEAT*FEAT_W  registered classifier input.
- mlp_out  in  CLS_W  classifier argmax output.
- m_cls_valid  out  1  result valid.
- m_cls_ready  in  1  downstream accepts result.
- m_cls_data  out  CLS_W  captured class index.
- err_frame  out  1  one-cycle pulse on a malformed frame.
- busy  out  1  high in any state except LOAD with idx==0.

Behaviour:
- Reset (async assert, sync release) values:
  - state=LOAD, idx=0, mlp_inp=0, m_cls_valid=0, m_cls_data=0, err_frame=0, settle counter=0.
  - s_feat_ready=1 from the first edge after release.
- A beat transfers when s_feat_valid && s_feat_ready on a rising edge.
- States:
  - LOAD: s_feat_ready=1.
    - Each transfer writes s_feat_data into mlp_inp[idx*FEAT_W +: FEAT_W], then idx++.
    - Slots not yet written keep their previous values.
    - Transfer with idx==NUM_FEAT-1 and last=1: go to SETTLE, counter=SETTLE_CYC-1, idx=0.
    - Transfer with last=1 and idx<NUM_FEAT-1 (early last): err_frame pulses the next cycle, idx=0, stay in LOAD. The frame is discarded and no result is produced.
    - Transfer with idx==NUM_FEAT-1 and last=0 (missing last): err_frame pulses, idx=0, go to DROP.
  - DROP: s_feat_ready=1.
    - Beats are consumed and ignored; mlp_inp is unchanged.
    - A transfer with last=1 returns to LOAD, idx=0.
  - SETTLE: s_feat_ready=0; mlp_inp must not change.
    - Counter decrements each cycle.
    - When counter==0: m_cls_data<=mlp_out, m_cls_valid<=1, go to HOLD.
  - HOLD: s_feat_ready=0.
    - m_cls_valid and m_cls_data are stable until m_cls_ready is sampled high.
    - On that edge: m_cls_valid<=0, go to LOAD. s_feat_ready=1 the following cycle; there is no same-cycle bypass.
- Timing:
  - The last beat transfers at edge T; mlp_inp is complete after T.
  - mlp_out is sampled at edge T+SETTLE_CYC; m_cls_valid is high from T+SETTLE_CYC.
  - With m_cls_ready tied high, the next frame's first beat can transfer at edge T+SETTLE_CYC+2.
  - Steady-state throughput is one frame per NUM_FEAT+SETTLE_CYC+1 cycles.
- mlp_inp changes only on a LOAD transfer, so it is glitch-free toward the combinational classifier during SETTLE and HOLD.
- No arithmetic beyond the idx counter (clog2(NUM_FEAT) bits, never wraps beyond NUM_FEAT-1) and the settle counter (8 bits).
- An rst_n assertion in any state aborts immediately to the reset values. A partial frame is lost and a pending result is dropped without handshake.
- err_frame is a single-cycle pulse per malformed frame. It is never asserted while m_cls_valid=1.

Test Plan:
- Reset then send beats 1,2,3,4,5,6,7,8 (last on 8th), m_cls_ready=1, classifier model output 2'b10:
  - mlp_inp=32'h87654321.
  - m_cls_valid rises exactly SETTLE_CYC=4 edges after the last transfer, with m_cls_data=2.
  - Next s_feat_ready follows one cycle after the result handshake.
- Hold m_cls_ready=0 for 10 cycles in HOLD, toggle the mlp_out model to 2'b01, and present feature beats:
  - m_cls_data stays at the captured value.
  - s_feat_ready stays 0; no beat is accepted.
  - Release ready: valid drops next cycle.
- Early last on the 3rd beat, then a good frame of all 4'hF:
  - err_frame pulses once; no result for the first frame.
  - Second frame gives mlp_inp=32'hFFFFFFFF and exactly one result.
- 8 beats without last, then 3 junk beats with last on the 3rd, then a good frame of 0..7:
  - err_frame pulses once; junk beats do not alter mlp_inp.
  - Good frame gives mlp_inp=32'h76543210 and one result.
- Random s_feat_valid gaps (50% duty) with a SETTLE_CYC=1 build: frame contents and order are preserved, and the result appears 1 edge after the last transfer.
- Assert rst_n low mid-SETTLE and mid-HOLD (asynchronously, between edges):
  - All outputs are at reset values immediately (mlp_inp=0, m_cls_valid=0).
  - No spurious result after release.
